// File: rtl/ai_pkg.sv
// Shared types and register map for the AI interrupt servicer.
// Unit scores live at word addresses 0..3; the ack register defaults to 5.
package ai_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_ACK,
      ST_DONE
   } ai_state_t;

   localparam int         AI_NUM_UNITS    = 4;
   localparam int         AI_SCORE_ADDR0  = 0;
   localparam int         AI_ACK_ADDR_DEF = 5;
   localparam logic [1:0] AI_LAST_IDX     = 2'(AI_NUM_UNITS - 1);

   function automatic logic [3:0] f_score_addr(input logic [1:0] idx);
      return 4'(AI_SCORE_ADDR0) + {2'b00, idx};
   endfunction

endpackage

// File: rtl/ai_wait_timer.sv
// Counts consecutive stall cycles; o_expire is high on the TIMEOUT_CYC-th one.
// Only instantiated when AI_SERVICER_TIMEOUT_EN is defined.
module ai_wait_timer #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic i_stall,
   output logic o_expire
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] r_cnt;

   assign o_expire = i_stall && (r_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         r_cnt <= '0;
      else if (!i_stall || o_expire)   r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/ai_irq_servicer.sv
// On irq_in, reads the four unit scores, acks the aggregator and reports the best unit.
// Define AI_SERVICER_TIMEOUT_EN to bound waitrequest stalls by TIMEOUT_CYC cycles.
module ai_irq_servicer
   import ai_pkg::*;
#(
   parameter int SCORE_W     = 32,
   parameter int ACK_ADDR    = AI_ACK_ADDR_DEF,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               irq_in,
   output logic [3:0]         avm_m0_address,
   output logic               avm_m0_read,
   output logic               avm_m0_write,
   output logic [SCORE_W-1:0] avm_m0_writedata,
   input  logic [SCORE_W-1:0] avm_m0_readdata,
   input  logic               avm_m0_waitrequest,
   output logic               busy,
   output logic               result_valid,
   output logic [1:0]         result_index,
   output logic [SCORE_W-1:0] result_score,
   output logic               timeout_err
);

   ai_state_t          r_state;
   logic [3:0]         r_addr;
   logic               r_read;
   logic               r_write;
   logic [1:0]         r_idx;
   logic [1:0]         r_best_idx;
   logic [SCORE_W-1:0] r_best_score;
   logic               r_res_valid;
   logic [1:0]         r_res_idx;
   logic [SCORE_W-1:0] r_res_score;
   logic               r_tmo;
   logic               w_expire;

`ifdef AI_SERVICER_TIMEOUT_EN
   logic w_stall;
   assign w_stall = ((r_state == ST_READ) || (r_state == ST_ACK)) && avm_m0_waitrequest;

   ai_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .i_stall  (w_stall),
      .o_expire (w_expire)
   );
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYC != 0);
   assign w_expire     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_idx        <= '0;
         r_best_idx   <= '0;
         r_best_score <= '0;
         r_res_valid  <= 1'b0;
         r_res_idx    <= '0;
         r_res_score  <= '0;
         r_tmo        <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         r_tmo       <= 1'b0;
         case (r_state)
            ST_IDLE: if (irq_in) begin
               r_idx        <= '0;
               r_best_idx   <= '0;
               r_best_score <= '0;
               r_addr       <= f_score_addr(2'd0);
               r_read       <= 1'b1;
               r_state      <= ST_READ;
            end
            ST_READ: if (w_expire) begin
               r_read  <= 1'b0;
               r_addr  <= '0;
               r_tmo   <= 1'b1;
               r_state <= ST_IDLE;
            end else if (!avm_m0_waitrequest) begin
               // strict compare: a tie keeps the earlier (lower) index
               if (avm_m0_readdata > r_best_score) begin
                  r_best_score <= avm_m0_readdata;
                  r_best_idx   <= r_idx;
               end
               if (r_idx == AI_LAST_IDX) begin
                  r_read  <= 1'b0;
                  r_write <= 1'b1;
                  r_addr  <= 4'(ACK_ADDR);
                  r_state <= ST_ACK;
               end else begin
                  r_idx  <= r_idx + 2'd1;
                  r_addr <= f_score_addr(r_idx + 2'd1);
               end
            end
            ST_ACK: if (w_expire) begin
               r_write <= 1'b0;
               r_addr  <= '0;
               r_tmo   <= 1'b1;
               r_state <= ST_IDLE;
            end else if (!avm_m0_waitrequest) begin
               r_write <= 1'b0;
               r_addr  <= '0;
               r_state <= ST_DONE;
            end
            // irq_in may still be high here from before the ack landed; ignore it
            ST_DONE: begin
               r_res_valid <= 1'b1;
               r_res_idx   <= r_best_idx;
               r_res_score <= r_best_score;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign avm_m0_address   = r_addr;
   assign avm_m0_read      = r_read;
   assign avm_m0_write     = r_write;
   assign avm_m0_writedata = '0;
   assign busy             = (r_state != ST_IDLE);
   assign result_valid     = r_res_valid;
   assign result_index     = r_res_idx;
   assign result_score     = r_res_score;
   assign timeout_err      = r_tmo;

endmodule

// File: tb/tb_ai_irq_servicer.sv
// Directed bench for ai_irq_servicer with a small score-slave model on the bus.
// Timeout case runs only when AI_SERVICER_TIMEOUT_EN is defined.
module tb_ai_irq_servicer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        irq = 1'b0;
   logic [3:0]  avm_address;
   logic        avm_read, avm_write;
   logic [31:0] avm_wdata, rdata;
   logic        wr;
   logic        busy, rv, tmo;
   logic [1:0]  ridx;
   logic [31:0] rscore;

   logic [31:0] scores [4];
   logic        stall_en  = 1'b0;
   logic        stuck_ack = 1'b0;
   int          stall_cnt = 0;
   int          cyc = 0;

   int n_chk = 0, n_err = 0;
   logic [3:0] rd_log [$];
   int ack_cnt = 0, rv_cnt = 0, tmo_cnt = 0, tmo_total = 0;
   int rv_cyc = 0, tmo_cyc = 0, ack_start = -1, irq_edge = 0;
   int ovl_err = 0, hold_err = 0, res_err = 0;
   logic       prev_stall = 1'b0;
   logic [3:0] prev_addr  = '0;
   logic [1:0] prev_idx   = '0;
   logic [31:0] prev_score = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rdata = (avm_read && avm_address < 4) ? scores[avm_address[1:0]] : 32'd0;
   assign wr = (stuck_ack && avm_write) ||
               (stall_en && avm_read && avm_address == 4'd2 && stall_cnt < 3);

   always @(posedge clk)
      if (stall_en && avm_read && avm_address == 4'd2 && stall_cnt < 3) stall_cnt <= stall_cnt + 1;

   ai_irq_servicer #(.SCORE_W(32), .ACK_ADDR(5), .TIMEOUT_CYC(8)) dut (
      .clk                (clk),
      .rst                (rst),
      .irq_in             (irq),
      .avm_m0_address     (avm_address),
      .avm_m0_read        (avm_read),
      .avm_m0_write       (avm_write),
      .avm_m0_writedata   (avm_wdata),
      .avm_m0_readdata    (rdata),
      .avm_m0_waitrequest (wr),
      .busy               (busy),
      .result_valid       (rv),
      .result_index       (ridx),
      .result_score       (rscore),
      .timeout_err        (tmo)
   );

   // bus/result monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         prev_idx   = ridx;
         prev_score = rscore;
         prev_stall = 1'b0;
      end else begin
         if (avm_read && avm_write) ovl_err++;
         if (avm_write && avm_wdata != 0) ovl_err++;
         if (prev_stall && (!avm_read || avm_address != prev_addr)) hold_err++;
         prev_stall = avm_read && wr;
         prev_addr  = avm_address;
         if (avm_read && !wr) rd_log.push_back(avm_address);
         if (avm_write && !wr && avm_address == 4'd5) ack_cnt++;
         if (avm_write && wr && ack_start < 0) ack_start = cyc;
         if (rv) begin
            rv_cnt++;
            rv_cyc = cyc;
         end else if (ridx != prev_idx || rscore != prev_score) res_err++;
         prev_idx   = ridx;
         prev_score = rscore;
         if (tmo) begin
            tmo_cnt++;
            tmo_total++;
            tmo_cyc = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_logs();
      rd_log.delete();
      ack_cnt = 0; rv_cnt = 0; tmo_cnt = 0; ack_start = -1;
   endtask

   task automatic set_scores(input logic [31:0] s0, s1, s2, s3);
      scores[0] = s0; scores[1] = s1; scores[2] = s2; scores[3] = s3;
   endtask

   task automatic wait_rv(input string tag, input int lim);
      int n = 0;
      while (rv_cnt == 0 && n < lim) begin
         @(posedge clk);
         n++;
      end
      if (rv_cnt == 0) chk({tag, "_rv_timeout"}, 0, 1);
   endtask

   task automatic chk_reads(input string tag);
      chk({tag, "_nreads"}, rd_log.size(), 4);
      for (int i = 0; i < 4 && i < rd_log.size(); i++) chk({tag, "_rdaddr"}, rd_log[i], i);
   endtask

   // one-cycle irq pulse; irq_edge is the clock edge that samples it
   task automatic pulse_irq();
      @(posedge clk); #1;
      irq = 1'b1;
      irq_edge = cyc + 1;
      @(posedge clk); #1;
      irq = 1'b0;
   endtask

   initial begin
      set_scores(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  busy, 0);
      chk("rst_read",  avm_read, 0);
      chk("rst_write", avm_write, 0);
      chk("rst_addr",  avm_address, 0);
      chk("rst_rv",    rv, 0);
      chk("rst_idx",   ridx, 0);
      chk("rst_score", rscore, 0);
      chk("rst_tmo",   tmo, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // basic: best is unit 1
      set_scores(10, 40, 25, 5);
      clr_logs();
      pulse_irq();
      wait_rv("t1", 40);
      chk("t1_latency", rv_cyc - irq_edge, 6);
      chk_reads("t1");
      repeat (3) @(posedge clk);
      #1;
      chk("t1_acks",  ack_cnt, 1);
      chk("t1_rvcnt", rv_cnt, 1);
      chk("t1_idx",   ridx, 1);
      chk("t1_score", rscore, 40);
      chk("t1_busy",  busy, 0);

      // ties keep the lowest index
      set_scores(7, 7, 3, 7);
      clr_logs();
      pulse_irq();
      wait_rv("t2", 40);
      repeat (2) @(posedge clk);
      #1;
      chk("t2_idx",   ridx, 0);
      chk("t2_score", rscore, 7);
      chk("t2_acks",  ack_cnt, 1);

      // three-cycle stall on the address-2 read
      set_scores(3, 9, 12, 2);
      stall_cnt = 0;
      stall_en  = 1'b1;
      clr_logs();
      pulse_irq();
      wait_rv("t3", 40);
      chk("t3_latency", rv_cyc - irq_edge, 9);
      chk("t3_stalls",  stall_cnt, 3);
      chk_reads("t3");
      repeat (2) @(posedge clk);
      #1;
      stall_en = 1'b0;
      chk("t3_idx",   ridx, 2);
      chk("t3_score", rscore, 12);
      chk("t3_hold",  hold_err, 0);

      // irq held through the ack, released one cycle after it
      set_scores(1, 2, 3, 4);
      clr_logs();
      @(posedge clk); #1;
      irq = 1'b1;
      begin
         int n = 0;
         while (ack_cnt == 0 && n < 40) begin
            @(posedge clk);
            n++;
         end
         if (ack_cnt == 0) chk("t4_ack_timeout", 0, 1);
      end
      @(posedge clk); #1;
      irq = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("t4_rvcnt", rv_cnt, 1);
      chk("t4_acks",  ack_cnt, 1);
      chk("t4_busy",  busy, 0);
      chk("t4_idx",   ridx, 3);
      chk("t4_score", rscore, 4);

      // reset while reading address 2, then rerun from the still-high irq
      set_scores(5, 6, 20, 1);
      clr_logs();
      @(posedge clk); #1;
      irq = 1'b1;
      begin
         int n = 0;
         while (!(avm_read && avm_address == 4'd2) && n < 40) begin
            @(negedge clk);
            n++;
         end
         if (!(avm_read && avm_address == 4'd2)) chk("t5_addr2_timeout", 0, 1);
      end
      #1;
      rst = 1'b1;
      #1;
      chk("t5_read",  avm_read, 0);
      chk("t5_write", avm_write, 0);
      chk("t5_addr",  avm_address, 0);
      chk("t5_busy",  busy, 0);
      chk("t5_idx",   ridx, 0);
      chk("t5_score", rscore, 0);
      chk("t5_noack", ack_cnt, 0);
      @(posedge clk);
      @(posedge clk); #1;
      clr_logs();
      rst = 1'b0;
      irq_edge = cyc + 1;
      @(posedge clk); #1;
      irq = 1'b0;
      wait_rv("t5", 40);
      chk("t5_latency", rv_cyc - irq_edge, 6);
      chk_reads("t5");
      repeat (2) @(posedge clk);
      #1;
      chk("t5_acks",   ack_cnt, 1);
      chk("t5_ridx",   ridx, 2);
      chk("t5_rscore", rscore, 20);

`ifdef AI_SERVICER_TIMEOUT_EN
      // ack stuck in waitrequest: timeout after 8 stall cycles
      stuck_ack = 1'b1;
      clr_logs();
      pulse_irq();
      begin
         int n = 0;
         while (tmo_cnt == 0 && n < 60) begin
            @(posedge clk);
            n++;
         end
         if (tmo_cnt == 0) chk("t6_tmo_timeout", 0, 1);
      end
      #1;
      stuck_ack = 1'b0;
      chk("t6_stall_cycles", tmo_cyc - ack_start, 8);
      repeat (2) @(posedge clk);
      #1;
      chk("t6_tmo_pulse", tmo, 0);
      chk("t6_busy",  busy, 0);
      chk("t6_rvcnt", rv_cnt, 0);
      chk("t6_acks",  ack_cnt, 0);
      chk("t6_idx",   ridx, 2);
      chk("t6_score", rscore, 20);
      chk("tmo_total", tmo_total, 1);
`else
      chk("tmo_total", tmo_total, 0);
`endif

      chk("overlap", ovl_err, 0);
      chk("res_hold", res_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ai_irq_servicer.md
AI_IRQ_SERVICER -- requirements
Module: ai_irq_servicer

Interface
REQ-001 SHALL have parameter SCORE_W, default 32: width of comparer score registers and of the data bus.
REQ-002 SHALL have parameter ACK_ADDR, default 5: word address written to clear the aggregated interrupt.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: waitrequest stall limit, used only under AI_SERVICER_TIMEOUT_EN.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port irq_in  in  1  level interrupt from the four-unit interrupt aggregator.
REQ-007 SHALL have port avm_m0_address  out  4  word address of the current master access.
REQ-008 SHALL have port avm_m0_read  out  1  read strobe.
REQ-009 SHALL have port avm_m0_write  out  1  write strobe.
REQ-010 SHALL have port avm_m0_writedata  out  SCORE_W  write data, always 0.
REQ-011 SHALL have port avm_m0_readdata  in  SCORE_W  read data, valid in any cycle where read=1 and waitrequest=0.
REQ-012 SHALL have port avm_m0_waitrequest  in  1  slave stall.
REQ-013 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 SHALL have port result_valid  out  1  one-cycle pulse marking a new result.
REQ-015 SHALL have port result_index  out  2  index (0-3) of the highest-scoring unit.
REQ-016 SHALL have port result_score  out  SCORE_W  score of that unit.
REQ-017 SHALL have port timeout_err  out  1  one-cycle pulse on bus timeout; constant 0 without the macro.

Function
REQ-018 SHALL implement FSM states IDLE, READ, ACK, DONE.
REQ-019 IDLE: irq_in=1 -> READ with read index 0, running best cleared to index 0, score 0.
REQ-020 READ: SHALL drive read=1, address=index; both held stable while waitrequest=1.
REQ-021 READ: on read & !waitrequest, SHALL replace the best only if readdata > best score (unsigned), so ties keep the lower index. Index 3 -> ACK; otherwise the index increments.
REQ-022 ACK: SHALL drive write=1, address=ACK_ADDR, writedata=0, held while waitrequest=1; accepted -> DONE.
REQ-023 DONE: SHALL pulse result_valid with result_index/result_score updated in the same cycle, then -> IDLE unconditionally; DONE masks the irq_in that is still high in the cycle after the ack.
REQ-024 result_index/result_score SHALL hold their value until the next DONE.
REQ-025 read and write SHALL never be asserted together; at most one access per accepted handshake.
REQ-026 irq_in falling during READ/ACK SHALL NOT abort the sequence.
REQ-027 Latency with zero waitrequest: irq_in seen in IDLE -> result_valid exactly 6 cycles later (4 reads, 1 write, DONE).

Reset
REQ-028 rst SHALL asynchronously force IDLE, read=0, write=0, address=0, busy=0, result_valid=0, result_index=0, result_score=0, timeout_err=0, and the timeout counter to 0.
REQ-029 Reset mid-sequence SHALL discard partial results with no ack write; a still-high irq_in restarts the sequence after reset release.

Configuration
REQ-030 With AI_SERVICER_TIMEOUT_EN defined, a counter SHALL count consecutive waitrequest=1 cycles in READ/ACK. On reaching TIMEOUT_CYC it SHALL drop strobes, pulse timeout_err, leave results unchanged, and -> IDLE.
REQ-031 Without AI_SERVICER_TIMEOUT_EN, no counter SHALL exist, waits SHALL be unbounded, and timeout_err SHALL be tied 0.

Structure
REQ-032 Shared package ai_pkg SHALL hold the FSM state enum, the result register map (scores at 0-3), and the default ACK_ADDR.
REQ-033 Timeout counter SHALL be sub-module ai_wait_timer, instantiated only under the macro.

Verification
REQ-034 Scores {10,40,25,5}, no waitrequest, irq pulse -> reads at addresses 0,1,2,3, write to 5, result_valid 6 cycles later, index=1, score=40.
REQ-035 Scores {7,7,3,7} -> index=0, score=7 (tie keeps the lowest index).
REQ-036 waitrequest=1 for 3 cycles on the address-2 read -> address/read held stable, result unchanged, result_valid 9 cycles after irq.
REQ-037 irq_in held high through the ack and released 1 cycle later -> exactly one result_valid and one ack write.
REQ-038 rst asserted while reading address 2 -> outputs 0 immediately, no write to 5; irq still high after release -> full sequence reruns from address 0.
REQ-039 Macro on, TIMEOUT_CYC=8, waitrequest stuck 1 in ACK -> timeout_err pulse after 8 stall cycles, FSM in IDLE, result_valid not pulsed.
